// File: rtl/ppu_mode_scheduler.sv
// LCD mode scheduler: owns dot/LY timing, sequences OAM search -> pixel transfer -> H-blank
// per visible line and V-blank afterwards, and generates LYC, STAT and V-blank interrupts.
module ppu_mode_scheduler #(
  parameter int LINE_CYCLES   = 456,
  parameter int VISIBLE_LINES = 144,
  parameter int VBLANK_LINES  = 10,
  parameter int M3_MAX_CYCLES = 289,
  parameter int DOT_W         = 9
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             lcd_en_in,
  input  logic [7:0]       lyc_in,
  input  logic [3:0]       stat_en_in,
  output logic             m2_start_out,
  input  logic             m2_done_in,
  output logic             m3_start_out,
  input  logic             m3_done_in,
  output logic [1:0]       mode_out,
  output logic [7:0]       ly_out,
  output logic [DOT_W-1:0] dot_out,
  output logic             lyc_eq_out,
  output logic             stat_irq_out,
  output logic             vblank_irq_out,
  output logic             overrun_out
);

  localparam int               TOTAL_LINES = VISIBLE_LINES + VBLANK_LINES;
  localparam logic [DOT_W-1:0] DOT_LAST    = DOT_W'(LINE_CYCLES - 1);
  localparam logic [7:0]       LY_LAST     = 8'(TOTAL_LINES - 1);
  localparam logic [8:0]       M3_LAST     = 9'(M3_MAX_CYCLES - 1);
  localparam logic [8:0]       VIS_LINES   = 9'(VISIBLE_LINES);

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [1:0] MODE_XFER   = 2'd3;

  typedef enum logic [2:0] {S_OFF, S_M2, S_M3, S_M0, S_M1} state_t;

  state_t           state_q;
  logic [DOT_W-1:0] dot_q;
  logic [7:0]       ly_q;
  logic [8:0]       m3_cnt_q;
  logic [1:0]       mode_q;
  logic             m2_start_q, m3_start_q, vblank_q, overrun_q;
  logic             lyc_eq_q, stat_prev_q, stat_irq_q;

  logic [7:0] ly_nxt;
  logic       line_end;
  logic       stat_line;

  assign ly_nxt   = (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
  assign line_end = (dot_q == DOT_LAST);

  // Built from registered state so the interrupt lags mode/lyc_eq by one cycle.
  assign stat_line = (state_q != S_OFF) &
                     ((lyc_eq_q & stat_en_in[3]) |
                      ((state_q == S_M2) & stat_en_in[2]) |
                      ((state_q == S_M1) & stat_en_in[1]) |
                      ((state_q == S_M0) & stat_en_in[0]));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_OFF;
      dot_q       <= '0;
      ly_q        <= '0;
      m3_cnt_q    <= '0;
      mode_q      <= MODE_HBLANK;
      m2_start_q  <= 1'b0;
      m3_start_q  <= 1'b0;
      vblank_q    <= 1'b0;
      overrun_q   <= 1'b0;
      lyc_eq_q    <= 1'b0;
      stat_prev_q <= 1'b0;
      stat_irq_q  <= 1'b0;
    end else begin
      m2_start_q  <= 1'b0;
      m3_start_q  <= 1'b0;
      vblank_q    <= 1'b0;
      lyc_eq_q    <= (ly_q == lyc_in);
      stat_prev_q <= stat_line;
      stat_irq_q  <= stat_line & ~stat_prev_q;

      if (!lcd_en_in) begin
        state_q     <= S_OFF;
        mode_q      <= MODE_HBLANK;
        dot_q       <= '0;
        ly_q        <= '0;
        m3_cnt_q    <= '0;
        overrun_q   <= 1'b0;
        stat_prev_q <= 1'b0;
        stat_irq_q  <= 1'b0;
      end else if (state_q == S_OFF) begin
        state_q    <= S_M2;
        mode_q     <= MODE_OAM;
        dot_q      <= '0;
        ly_q       <= '0;
        m2_start_q <= 1'b1;
      end else if (line_end) begin
        // Line boundary is fixed; it wins over any done arriving in the same cycle.
        dot_q <= '0;
        ly_q  <= ly_nxt;
        if (state_q == S_M2 || state_q == S_M3)
          overrun_q <= 1'b1;
        if ({1'b0, ly_nxt} < VIS_LINES) begin
          state_q    <= S_M2;
          mode_q     <= MODE_OAM;
          m2_start_q <= 1'b1;
        end else begin
          state_q  <= S_M1;
          mode_q   <= MODE_VBLANK;
          vblank_q <= ({1'b0, ly_nxt} == VIS_LINES);
        end
      end else begin
        dot_q <= dot_q + 1'b1;
        case (state_q)
          S_M2: if (m2_done_in) begin
            state_q    <= S_M3;
            mode_q     <= MODE_XFER;
            m3_start_q <= 1'b1;
            m3_cnt_q   <= '0;
          end
          S_M3: if (m3_done_in || m3_cnt_q == M3_LAST) begin
            state_q <= S_M0;
            mode_q  <= MODE_HBLANK;
          end else begin
            m3_cnt_q <= m3_cnt_q + 9'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign m2_start_out   = m2_start_q;
  assign m3_start_out   = m3_start_q;
  assign mode_out       = mode_q;
  assign ly_out         = ly_q;
  assign dot_out        = dot_q;
  assign lyc_eq_out     = lyc_eq_q;
  assign stat_irq_out   = stat_irq_q;
  assign vblank_irq_out = vblank_q;
  assign overrun_out    = overrun_q;

endmodule

// File: tb/tb_ppu_mode_scheduler.sv
// Bench for ppu_mode_scheduler: dot-arithmetic reference model checked every cycle,
// directed frame with literal expectations, then randomized handshakes/enables/resets.
module tb_ppu_mode_scheduler;
  localparam int LC = 100, VIS = 4, VB = 2, M3M = 40, DW = 7, TOT = VIS + VB;
  localparam int INF = 1000000;

  logic          clk = 1'b0, rst_n = 1'b0, lcd_en = 1'b0, m2_done = 1'b0, m3_done = 1'b0;
  logic [7:0]    lyc = 8'd2;
  logic [3:0]    stat_en = 4'b1001;
  logic          m2_start, m3_start, lyc_eq, stat_irq, vblank_irq, overrun;
  logic [1:0]    mode;
  logic [7:0]    ly;
  logic [DW-1:0] dot;

  ppu_mode_scheduler #(.LINE_CYCLES(LC), .VISIBLE_LINES(VIS), .VBLANK_LINES(VB),
                       .M3_MAX_CYCLES(M3M), .DOT_W(DW)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .lcd_en_in(lcd_en), .lyc_in(lyc), .stat_en_in(stat_en),
    .m2_start_out(m2_start), .m2_done_in(m2_done), .m3_start_out(m3_start), .m3_done_in(m3_done),
    .mode_out(mode), .ly_out(ly), .dot_out(dot), .lyc_eq_out(lyc_eq), .stat_irq_out(stat_irq),
    .vblank_irq_out(vblank_irq), .overrun_out(overrun));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Mode at a given dot of a line, given where OAM search and transfer ended.
  function automatic int mode_of(bit on, int d, int l, int m2_end, int m3_end);
    if (!on) return 0;
    if (l >= VIS) return 1;
    if (d < m2_end) return 2;
    if (d < m3_end) return 3;
    return 0;
  endfunction

  // Reference model: current-cycle expectations, compared then advanced each negedge.
  bit on = 0, e_ovr = 0, e_lyceq = 0, e_sirq = 0, e_vb = 0, e_m2s = 0, e_m3s = 0, prev_line = 0;
  int e_dot = 0, e_ly = 0, m2_end = INF, m3_end = INF;

  initial begin : model
    int md;
    bit line, n_lyceq;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        on = 0; e_dot = 0; e_ly = 0; e_ovr = 0; e_lyceq = 0; e_sirq = 0;
        e_vb = 0; e_m2s = 0; e_m3s = 0; prev_line = 0;
      end
      md = mode_of(on, e_dot, e_ly, m2_end, m3_end);
      chk("mode", 32'(mode), 32'(md));
      chk("ly", 32'(ly), 32'(e_ly));
      chk("dot", 32'(dot), 32'(e_dot));
      chk("lyc_eq", 32'(lyc_eq), 32'(e_lyceq));
      chk("stat_irq", 32'(stat_irq), 32'(e_sirq));
      chk("vblank_irq", 32'(vblank_irq), 32'(e_vb));
      chk("m2_start", 32'(m2_start), 32'(e_m2s));
      chk("m3_start", 32'(m3_start), 32'(e_m3s));
      chk("overrun", 32'(overrun), 32'(e_ovr));
      if (rst_n) begin
        line = on && ((e_lyceq && stat_en[3]) || (md == 2 && stat_en[2]) ||
                      (md == 1 && stat_en[1]) || (md == 0 && stat_en[0]));
        n_lyceq = (e_ly == int'(lyc));
        e_vb = 0; e_m2s = 0; e_m3s = 0;
        e_lyceq = n_lyceq;
        if (!lcd_en) begin
          on = 0; e_dot = 0; e_ly = 0; e_ovr = 0; e_sirq = 0; prev_line = 0;
        end else begin
          e_sirq = line && !prev_line;
          prev_line = line;
          if (!on) begin
            on = 1; e_dot = 0; e_ly = 0; m2_end = INF; m3_end = INF; e_m2s = 1;
          end else if (e_dot == LC - 1) begin
            if (md == 2 || md == 3) e_ovr = 1;
            e_dot = 0;
            e_ly = (e_ly + 1) % TOT;
            m2_end = INF; m3_end = INF;
            e_m2s = (e_ly < VIS);
            e_vb = (e_ly == VIS);
          end else begin
            if (md == 2 && m2_done) begin
              m2_end = e_dot + 1; m3_end = e_dot + 1 + M3M; e_m3s = 1;
            end else if (md == 3 && m3_done) begin
              m3_end = e_dot + 1;
            end
            e_dot++;
          end
        end
      end
    end
  end

  initial begin : stim
    int n_m2s, n_vb, n_sirq, p2, p3, off_cnt;
    n_m2s = 0; n_vb = 0; n_sirq = 0; p2 = 1; p3 = 1; off_cnt = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mode", 32'(mode), 0);
    chk("reset_overrun", 32'(overrun), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 lcd_en = 1'b1;
    @(posedge clk); #1;

    // Directed: k counts cycles from the first M2 cycle (dot 0 of line 0).
    for (int k = 0; k < 900; k++) begin
      m2_done = (k == 19) || (k == 60) || (k == 110) || (k == 215) || (k == 315) || (k == 720);
      m3_done = (k == 5) || (k == 50) || (k == 240) || (k == 340) || (k == 403) || (k == 760);
      lcd_en  = !(k >= 830 && k <= 834);
      @(negedge clk);
      if (k < 600) begin
        n_m2s += int'(m2_start); n_vb += int'(vblank_irq); n_sirq += int'(stat_irq);
      end
      case (k)
        0:   begin chk("k0_m2_start", 32'(m2_start), 1); chk("k0_mode", 32'(mode), 2); end
        19:  chk("k19_mode", 32'(mode), 2);
        20:  begin chk("k20_mode", 32'(mode), 3); chk("k20_m3_start", 32'(m3_start), 1); end
        50:  chk("k50_mode", 32'(mode), 3);
        51:  chk("k51_mode", 32'(mode), 0);
        150: chk("timeout_k150_mode", 32'(mode), 3);
        151: chk("timeout_k151_mode", 32'(mode), 0);
        202: chk("lyc_stat_pulse", 32'(stat_irq), 1);
        242: chk("m0_blocked", 32'(stat_irq), 0);
        342: chk("m0_line3_pulse", 32'(stat_irq), 1);
        399: chk("k399_vblank", 32'(vblank_irq), 0);
        400: begin chk("k400_vblank", 32'(vblank_irq), 1); chk("k400_ly", 32'(ly), 4);
                   chk("k400_mode", 32'(mode), 1); end
        599: begin chk("k599_ly", 32'(ly), 5); chk("k599_dot", 32'(dot), 99); end
        600: begin chk("frame_ly", 32'(ly), 0); chk("frame_dot", 32'(dot), 0);
                   chk("frame_mode", 32'(mode), 2); end
        699: chk("k699_overrun", 32'(overrun), 0);
        700: begin chk("k700_overrun", 32'(overrun), 1); chk("k700_mode", 32'(mode), 2);
                   chk("k700_m2_start", 32'(m2_start), 1); end
        831: begin chk("off_ly", 32'(ly), 0); chk("off_mode", 32'(mode), 0);
                   chk("off_overrun", 32'(overrun), 0); chk("off_dot", 32'(dot), 0); end
        835: chk("k835_mode", 32'(mode), 0);
        836: begin chk("reen_mode", 32'(mode), 2); chk("reen_m2_start", 32'(m2_start), 1); end
        default: ;
      endcase
      @(posedge clk); #1;
    end
    chk("frame_m2_start_count", 32'(n_m2s), 4);
    chk("frame_vblank_count", 32'(n_vb), 1);
    chk("frame_stat_count", 32'(n_sirq), 4);

    // Reset asserted mid-cycle takes effect before the next edge.
    m2_done = 1'b0; m3_done = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("async_rst_dot", 32'(dot), 0);
    chk("async_rst_mode", 32'(mode), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        p2 = int'($urandom_range(1, 30));
        p3 = int'($urandom_range(1, 60));
      end
      m2_done = ($urandom % p2) == 0;
      m3_done = ($urandom % p3) == 0;
      if (i % 47 == 0) lyc = 8'($urandom_range(0, 6));
      if (i % 61 == 0) stat_en = 4'($urandom);
      if (off_cnt > 0) begin
        off_cnt--; lcd_en = 1'b0;
      end else if ($urandom % 400 == 0) begin
        off_cnt = int'($urandom_range(0, 4)); lcd_en = 1'b0;
      end else begin
        lcd_en = 1'b1;
      end
      rst_n = ($urandom % 1500) != 0;
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ppu_mode_scheduler.md
# ppu_mode_scheduler

Parametrised LCD mode scheduler for the PPU. It owns the dot counter, the LY counter, the mode sequence (2 → 3 → 0 per visible line, then 1 for vertical blank) and the start/done handshakes with the OAM-search and pixel-fetch engines. It also generates LYC coincidence, an edge-detected STAT interrupt and a V-blank interrupt. It sits between the PPU MMIO register file and the mode 2/mode 3 engines, replacing hard-coded 456/144/10 timing with parameters and adding a mode 3 timeout, an overrun flag and proper LCD-off behaviour.

## Interface
Parameters:
- LINE_CYCLES, 456, dots per scanline (≥ 16).
- VISIBLE_LINES, 144, lines with modes 2/3/0.
- VBLANK_LINES, 10, lines in mode 1; total lines = VISIBLE_LINES + VBLANK_LINES ≤ 256.
- M3_MAX_CYCLES, 289, mode 3 timeout in dots.
- DOT_W, 9, dot counter width; must hold LINE_CYCLES-1.

Ports:
- clk_in  in  1  PPU dot clock.
- rst_n_in  in  1  Reset. Asynchronous, active-low.
- lcd_en_in  in  1  LCDC bit 7. Low forces the LCD-off state.
- lyc_in  in  8  LYC register.
- stat_en_in  in  4  STAT enables: [3] LYC, [2] mode 2, [1] mode 1, [0] mode 0.
- m2_start_out  out  1  One-cycle start pulse to OAM search.
- m2_done_in  in  1  OAM search done (level or pulse; first high sample counts).
- m3_start_out  out  1  One-cycle start pulse to the pixel fetcher.
- m3_done_in  in  1  Pixel fetcher done.
- mode_out  out  2  Current mode, in STAT[1:0] encoding.
- ly_out  out  8  Current line.
- dot_out  out  DOT_W  Dot index within the line.
- lyc_eq_out  out  1  Registered (ly == lyc_in).
- stat_irq_out  out  1  One-cycle pulse on a rising edge of the STAT line.
- vblank_irq_out  out  1  One-cycle pulse on entry to mode 1.
- overrun_out  out  1  Sticky flag: a line ended while still in mode 2 or mode 3.

## Operation
- **States:** OFF, M2, M3, M0, M1. All outputs are registered.
- **Reset and OFF values:** In reset, and whenever lcd_en_in is sampled low, the block enters OFF. In OFF: dot=0, ly=0, mode_out=0, all pulses 0, STAT line 0, overrun_out=0. lyc_eq_out keeps comparing against ly=0.
- **Leaving OFF:** When lcd_en_in is sampled high in OFF, the next cycle is dot=0, ly=0, M2, with m2_start_out=1.
- **Dot counter:** Increments every cycle outside OFF. At LINE_CYCLES-1 it wraps to 0 and ly increments. ly wraps from total-1 to 0.
- **Line start, visible line:** At dot 0 with ly < VISIBLE_LINES, the state is M2 and m2_start_out=1 for that cycle only.
- **M2 → M3:** When m2_done_in is sampled high in M2, the next cycle is M3 with m3_start_out=1. A 9-bit m3 counter resets to 0.
- **M3 → M0:** M3 exits to M0 on the cycle after m3_done_in is sampled high, or after the m3 counter reaches M3_MAX_CYCLES-1, whichever comes first.
- **M0:** Held until the line wraps.
- **Overrun:** If the line wraps while in M2 or M3, the line is aborted, overrun_out is set, and the next line starts normally. Done inputs are ignored outside the state that expects them.
- **Entering V-blank:** When ly becomes VISIBLE_LINES, the state is M1 and vblank_irq_out=1 for that cycle. M1 is held for VBLANK_LINES full lines.
- **Leaving V-blank:** On the wrap from ly=total-1 to ly=0, the state is M2 with m2_start_out=1.
- **STAT line:** (lyc_eq & en[3]) | (M2 & en[2]) | (M1 & en[1]) | (M0 & en[0]). stat_irq_out pulses only on a 0→1 transition of this line relative to its previous-cycle value. While the line stays high across a mode change, no further pulse is issued (STAT blocking).
- **Simultaneous events:** If a line wrap coincides with m2_done or m3_done, the wrap wins. lcd_en_in low overrides everything.

## Timing
- Start pulses are issued in the first cycle of their mode; done→next-mode latency is 1 cycle.
- Line period is exactly LINE_CYCLES dots, independent of how long mode 3 takes. Frame period is LINE_CYCLES × (VISIBLE_LINES + VBLANK_LINES); 70224 at the defaults.
- lyc_eq_out lags ly_out by 1 cycle, and stat_irq_out lags lyc_eq_out and mode_out by 1 cycle.
- Asynchronous reset assertion takes effect immediately, including mid-line. Release is synchronous to clk_in, and the block leaves OFF on the first cycle after release in which lcd_en_in is high.

## Test plan
- **Normal line:** Defaults, enable high, m2_done at dot 79, m3_done at dot 251 → m2_start at dot 0; mode 3 and m3_start at dot 80; mode 0 at dot 252; ly=1 at dot 0, 456 cycles after the start.
- **Full frame:** Run one frame → vblank_irq_out pulses once, at ly=144 dot 0; ly returns to 0 after 70224 cycles; m2_start pulses 144 times.
- **Timeout and overrun:** m3_done never asserted → M0 entered after 289 dots of M3. Separately, m2_done never asserted → overrun_out=1 after dot 455 and the next line still starts in M2.
- **LYC and STAT blocking:** lyc_in=5, stat_en=4'b1001 → stat_irq_out pulses once at the start of ly=5. Mode 0 entry on line 5 produces no pulse. Mode 0 entry on line 6 pulses.
- **LCD off mid-frame:** Drop lcd_en at ly=60 → next cycle ly=0, mode 0, overrun cleared. Re-enable → M2 with m2_start the following cycle.
- **Parametrised config:** LINE_CYCLES=100, VISIBLE_LINES=4, VBLANK_LINES=2 → frame period 600; vblank_irq at cycle 400.
